// File: rtl/plic_routing_scan.sv
// Sequential PLIC routing: sweeps CHUNK source IDs per cycle to find, per target, the
// highest-priority enabled pending source. Optional per-target threshold: PLIC_ROUTING_THRESHOLD_EN.
module plic_routing_scan #(
    parameter int SRC_N  = 31,
    parameter int TGT_N  = 1,
    parameter int PRIO_W = 3,
    parameter int CHUNK  = 4,
    localparam int SRC_W = $clog2(SRC_N + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [SRC_N:0]                int_pending_i,
    input  logic [(SRC_N+1)*PRIO_W-1:0]   cfg_int_prio_i,
    input  logic [TGT_N*(SRC_N+1)-1:0]    cfg_int_enable_i,
`ifdef PLIC_ROUTING_THRESHOLD_EN
    input  logic [TGT_N*PRIO_W-1:0]       cfg_threshold_i,
`endif
    input  logic                          sweep_restart_i,
    output logic [TGT_N*PRIO_W-1:0]       max_prio_o,
    output logic [TGT_N*SRC_W-1:0]        max_src_o,
    output logic                          sweep_done_o
);

    localparam int STEPS = (SRC_N + CHUNK) / CHUNK;
    localparam int NPAD  = STEPS * CHUNK;
    localparam int NPW   = $clog2(NPAD);
    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(STEPS - 1);

    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NPW-1:0]                   base;
    logic [TGT_N-1:0][PRIO_W-1:0]     thr;
    logic [PRIO_W-1:0]                eff [TGT_N][NPAD];
    logic [TGT_N-1:0][PRIO_W-1:0]     cb_prio, mg_prio, acc_prio_q, acc_prio_d, max_prio_q, max_prio_d;
    logic [TGT_N-1:0][SRC_W-1:0]      cb_src, mg_src, acc_src_q, acc_src_d, max_src_q, max_src_d;
    logic                             done_q, done_d;
    logic [TGT_N-1:0]                 unused_en0;
    logic                             unused_id0;

`ifdef PLIC_ROUTING_THRESHOLD_EN
    assign thr = cfg_threshold_i;
`else
    assign thr = '0;
`endif

    // Effective priority table, padded to a whole number of chunks; ID 0 and padding are 0.
    for (genvar j = 0; j < TGT_N; j++) begin : g_tgt
        assign unused_en0[j] = cfg_int_enable_i[j*(SRC_N+1)];
        for (genvar i = 0; i < NPAD; i++) begin : g_src
            if (i == 0 || i > SRC_N) begin : g_zero
                assign eff[j][i] = '0;
            end else begin : g_live
                assign eff[j][i] = (cfg_int_enable_i[j*(SRC_N+1)+i] && int_pending_i[i] &&
                                    cfg_int_prio_i[i*PRIO_W +: PRIO_W] > thr[j])
                                   ? cfg_int_prio_i[i*PRIO_W +: PRIO_W] : '0;
            end
        end
    end
    assign unused_id0 = ^{unused_en0, int_pending_i[0], cfg_int_prio_i[PRIO_W-1:0]};

    assign base = NPW'(idx_q) * NPW'(CHUNK);

    always_comb begin
        idx_d      = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        cb_prio    = '0;
        cb_src     = '0;
        mg_prio    = '0;
        mg_src     = '0;
        acc_prio_d = '0;
        acc_src_d  = '0;
        max_prio_d = max_prio_q;
        max_src_d  = max_src_q;
        done_d     = (idx_q == LAST);
        for (int j = 0; j < TGT_N; j++) begin
            // Ascending scan with strict compare keeps the lowest ID on ties.
            for (int c = 0; c < CHUNK; c++) begin
                if (eff[j][base + NPW'(c)] > cb_prio[j]) begin
                    cb_prio[j] = eff[j][base + NPW'(c)];
                    cb_src[j]  = SRC_W'(base + NPW'(c));
                end
            end
            if (idx_q == '0 || cb_prio[j] > acc_prio_q[j]) begin
                mg_prio[j] = cb_prio[j];
                mg_src[j]  = cb_src[j];
            end else begin
                mg_prio[j] = acc_prio_q[j];
                mg_src[j]  = acc_src_q[j];
            end
            acc_prio_d[j] = mg_prio[j];
            acc_src_d[j]  = mg_src[j];
            if (idx_q == LAST) begin
                max_prio_d[j] = mg_prio[j];
                max_src_d[j]  = mg_src[j];
            end
        end
        // Restart wins over a coinciding last step: nothing is published.
        if (sweep_restart_i) begin
            idx_d      = '0;
            acc_prio_d = '0;
            acc_src_d  = '0;
            max_prio_d = max_prio_q;
            max_src_d  = max_src_q;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q      <= '0;
            acc_prio_q <= '0;
            acc_src_q  <= '0;
            max_prio_q <= '0;
            max_src_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            acc_prio_q <= acc_prio_d;
            acc_src_q  <= acc_src_d;
            max_prio_q <= max_prio_d;
            max_src_q  <= max_src_d;
            done_q     <= done_d;
        end
    end

    assign max_prio_o   = max_prio_q;
    assign max_src_o    = max_src_q;
    assign sweep_done_o = done_q;

endmodule
